// File: rtl/e203_dtcm_sram_icb_ctrl.sv
// Purpose  : ICB command/response front end for the DTCM single-port SRAM macro (1-cycle read latency).
// Latency  : command fired in cycle N returns its response (data or range error) in cycle N+1.
// Backpres.: a stalled response holds stage 1; the optional skid register decouples cmd_ready from rsp_ready.
//
// Optional feature macro: E203_DTCM_SRAM_RSP_SKID_EN
//   undefined : cmd_ready = ctrl_en & (~stg1_vld | rsp_ready), response from stage 1 only
//   defined   : 1-entry response skid register, cmd_ready = ctrl_en & ~skid_vld (registered only)
//
// Ports:
//   clk, rst_n                       core clock, asynchronous active-low reset
//   i_icb_cmd_{valid,ready,addr,read,wdata,wmask}  command channel (addr is a byte offset)
//   i_icb_rsp_{valid,ready,rdata,err}              response channel (rdata=0 for writes/errors)
//   ram_{cs,we,addr,wem,din}         SRAM drive, combinational from the firing command
//   ram_dout                         SRAM read data, valid the cycle after a read cs, held until next cs
module e203_dtcm_sram_icb_ctrl #(
  parameter int ADDR_W = 16,
  parameter int RAM_AW = 13,
  parameter int DW     = 32,
  parameter int MW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_icb_cmd_valid,
  output logic              i_icb_cmd_ready,
  input  logic [ADDR_W-1:0] i_icb_cmd_addr,
  input  logic              i_icb_cmd_read,
  input  logic [DW-1:0]     i_icb_cmd_wdata,
  input  logic [MW-1:0]     i_icb_cmd_wmask,
  output logic              i_icb_rsp_valid,
  input  logic              i_icb_rsp_ready,
  output logic [DW-1:0]     i_icb_rsp_rdata,
  output logic              i_icb_rsp_err,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [MW-1:0]     ram_wem,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout
);

  logic          ctrl_en;
  logic          cmd_fire;
  logic          oor;
  logic          stg1_vld;
  logic          stg1_read;
  logic          stg1_err;
  logic          stg1_free;
  logic [DW-1:0] stg1_rdata;

  assign cmd_fire = i_icb_cmd_valid & i_icb_cmd_ready;

  // Addresses never wrap: any bit above the macro's byte range flags an error.
  assign oor = |i_icb_cmd_addr[ADDR_W-1:RAM_AW+2];

  assign ram_cs   = cmd_fire & ~oor;
  assign ram_we   = ~i_icb_cmd_read;
  assign ram_addr = i_icb_cmd_addr[RAM_AW+1:2];
  assign ram_wem  = i_icb_cmd_wmask;
  assign ram_din  = i_icb_cmd_wdata;

  // Only a good read returns macro data; writes and errors return zero.
  assign stg1_rdata = (stg1_read & ~stg1_err) ? ram_dout : '0;

  // Holds cmd_ready low for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_en <= 1'b0;
    else        ctrl_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg1_vld  <= 1'b0;
      stg1_read <= 1'b0;
      stg1_err  <= 1'b0;
    end else if (cmd_fire) begin
      stg1_vld  <= 1'b1;
      stg1_read <= i_icb_cmd_read;
      stg1_err  <= oor;
    end else if (stg1_free) begin
      stg1_vld  <= 1'b0;
    end
  end

`ifdef E203_DTCM_SRAM_RSP_SKID_EN
  logic          skid_vld;
  logic          skid_err;
  logic [DW-1:0] skid_rdata;
  logic          skid_load;

  // Park a stalled stage-1 response so stage 1 (and ram_dout) can take one more command.
  assign skid_load = stg1_vld & ~skid_vld & ~i_icb_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld   <= 1'b0;
      skid_err   <= 1'b0;
      skid_rdata <= '0;
    end else if (skid_load) begin
      skid_vld   <= 1'b1;
      skid_err   <= stg1_err;
      skid_rdata <= stg1_rdata;
    end else if (skid_vld & i_icb_rsp_ready) begin
      skid_vld   <= 1'b0;
    end
  end

  // With the skid empty, stage 1 always leaves: either handshaken out or moved into the skid.
  // While the skid is full, cmd_ready=0 so no cs can disturb ram_dout for the held stage-1 read.
  assign stg1_free       = stg1_vld & ~skid_vld;
  assign i_icb_cmd_ready = ctrl_en & ~skid_vld;
  assign i_icb_rsp_valid = skid_vld | stg1_vld;
  assign i_icb_rsp_rdata = skid_vld ? skid_rdata : stg1_rdata;
  assign i_icb_rsp_err   = skid_vld ? skid_err   : stg1_err;
`else
  // New command only when stage 1 is empty or is being consumed this cycle,
  // so ram_dout is never overwritten under an unconsumed read.
  assign stg1_free       = stg1_vld & i_icb_rsp_ready;
  assign i_icb_cmd_ready = ctrl_en & (~stg1_vld | i_icb_rsp_ready);
  assign i_icb_rsp_valid = stg1_vld;
  assign i_icb_rsp_rdata = stg1_rdata;
  assign i_icb_rsp_err   = stg1_err;
`endif

endmodule
